// File: rtl/simple_ctrl_pkg.sv
// Shared types and defaults for the phase sequencer.
// The state encodings are visible on state_out, so they must not be reordered.
package simple_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StRun       = 3'd1,
        StStepInsn  = 3'd2,
        StStepPhase = 3'd3,
        StHalted    = 3'd4
    } state_e;

    localparam int unsigned DefNumPhases  = 5;
    localparam int unsigned DefPhaseWidth = 2;
    localparam int unsigned DefCountWidth = 16;

    function automatic logic is_active(input state_e s);
        return (s == StRun) || (s == StStepInsn) || (s == StStepPhase);
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Tick counter split into phase index and sub-phase cycle.
// It advances by one tick per enabled cycle and wraps after the last tick of the last phase.
module phase_timer #(
    parameter int unsigned NUM_PHASES  = 5,
    parameter int unsigned PHASE_WIDTH = 2
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          advance,
    output logic                          phase_start,
    output logic                          phase_end,
    output logic                          wrap,
    output logic [$clog2(NUM_PHASES)-1:0] phase_idx
);

    localparam int unsigned PhW  = $clog2(NUM_PHASES);
    // A one-bit sub counter is kept when PHASE_WIDTH is 1; it then stays at zero.
    localparam int unsigned SubW = (PHASE_WIDTH > 1) ? $clog2(PHASE_WIDTH) : 1;
    localparam logic [PhW-1:0]  LastPhase = PhW'(NUM_PHASES - 1);
    localparam logic [SubW-1:0] LastSub   = SubW'(PHASE_WIDTH - 1);

    logic [PhW-1:0]  phase_q, phase_d;
    logic [SubW-1:0] sub_q, sub_d;

    assign phase_start = (sub_q == '0);
    assign phase_end   = (sub_q == LastSub);
    assign wrap        = phase_end && (phase_q == LastPhase);
    assign phase_idx   = phase_q;

    always_comb begin
        phase_d = phase_q;
        sub_d   = sub_q;
        if (advance) begin
            if (phase_end) begin
                sub_d   = '0;
                phase_d = (phase_q == LastPhase) ? '0 : phase_q + 1'b1;
            end else begin
                sub_d = sub_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= '0;
            sub_q   <= '0;
        end else begin
            phase_q <= phase_d;
            sub_q   <= sub_d;
        end
    end

endmodule

// File: rtl/phase_sequencer.sv
// Multi-phase instruction clock controller: free-run, instruction step, phase step and halt.
// Outputs are decoded only from registered state, so they are glitch-free.
module phase_sequencer
    import simple_ctrl_pkg::*;
#(
    parameter int unsigned NUM_PHASES  = DefNumPhases,
    parameter int unsigned PHASE_WIDTH = DefPhaseWidth,
    parameter int unsigned COUNT_WIDTH = DefCountWidth
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          run,
    input  logic                          step_insn,
    input  logic                          step_phase,
    input  logic                          halt_in,
    output logic [NUM_PHASES-1:0]         phase_pulse,
    output logic [$clog2(NUM_PHASES)-1:0] phase_idx,
    output logic                          insn_done,
    output logic [COUNT_WIDTH-1:0]        insn_count,
    output logic [2:0]                    state_out,
    output logic                          running,
    output logic                          halted
);

    state_e                 state_q, state_d;
    logic                   halt_pending_q;
    logic [COUNT_WIDTH-1:0] insn_count_q;
    logic                   active;
    logic                   phase_start;
    logic                   phase_end;
    logic                   wrap;
    logic                   at_insn_start;

    assign active = is_active(state_q);

    phase_timer #(
        .NUM_PHASES  (NUM_PHASES),
        .PHASE_WIDTH (PHASE_WIDTH)
    ) u_timer (
        .clock       (clock),
        .reset_n     (reset_n),
        .advance     (active),
        .phase_start (phase_start),
        .phase_end   (phase_end),
        .wrap        (wrap),
        .phase_idx   (phase_idx)
    );

    assign at_insn_start = phase_start && (phase_idx == '0);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                // A halt latched on an earlier edge wins over any request at an insn boundary.
                if (halt_pending_q && at_insn_start) begin
                    state_d = StHalted;
                end else if (run) begin
                    state_d = StRun;
                end else if (step_insn) begin
                    state_d = StStepInsn;
                end else if (step_phase) begin
                    state_d = StStepPhase;
                end
            end
            StRun: begin
                if (wrap) begin
                    if (halt_pending_q) begin
                        state_d = StHalted;
                    end else if (!run) begin
                        state_d = StIdle;
                    end
                end
            end
            StStepInsn: begin
                if (wrap) begin
                    state_d = halt_pending_q ? StHalted : StIdle;
                end
            end
            StStepPhase: begin
                if (phase_end) begin
                    state_d = (wrap && halt_pending_q) ? StHalted : StIdle;
                end
            end
            StHalted: state_d = StHalted;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= StIdle;
            halt_pending_q <= 1'b0;
            insn_count_q   <= '0;
        end else begin
            state_q        <= state_d;
            halt_pending_q <= halt_pending_q | halt_in;
            if (insn_done) begin
                insn_count_q <= insn_count_q + 1'b1;
            end
        end
    end

    assign insn_done = active && wrap;

    always_comb begin
        phase_pulse = '0;
        if (active && phase_start) begin
            phase_pulse[phase_idx] = 1'b1;
        end
    end

    assign insn_count = insn_count_q;
    assign state_out  = state_q;
    assign running    = active;
    assign halted     = (state_q == StHalted);

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed and random stimulus for phase_sequencer, checked against a tick-level reference model.
module tb_phase_sequencer;

    localparam int NP = 5;
    localparam int PW = 2;
    localparam int CW = 16;
    localparam int TICKS = NP * PW;

    localparam int MIdle = 0;
    localparam int MRun = 1;
    localparam int MStepInsn = 2;
    localparam int MStepPhase = 3;
    localparam int MHalted = 4;

    logic          clock;
    logic          reset_n;
    logic          run;
    logic          step_insn;
    logic          step_phase;
    logic          halt_in;
    logic [NP-1:0] phase_pulse;
    logic [2:0]    phase_idx;
    logic          insn_done;
    logic [CW-1:0] insn_count;
    logic [2:0]    state_out;
    logic          running;
    logic          halted;

    phase_sequencer #(
        .NUM_PHASES  (NP),
        .PHASE_WIDTH (PW),
        .COUNT_WIDTH (CW)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .run         (run),
        .step_insn   (step_insn),
        .step_phase  (step_phase),
        .halt_in     (halt_in),
        .phase_pulse (phase_pulse),
        .phase_idx   (phase_idx),
        .insn_done   (insn_done),
        .insn_count  (insn_count),
        .state_out   (state_out),
        .running     (running),
        .halted      (halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_assert = 0;
    int n_fail = 0;

    // Reference model: mode, absolute tick, ticks left in a step, halt latch, retired count.
    int m_mode;
    int m_t;
    int m_left;
    bit m_hp;
    int m_count;

    int seen_pulses;
    int seen_done;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = MIdle;
        m_t = 0;
        m_left = 0;
        m_hp = 1'b0;
        m_count = 0;
    endtask

    task automatic model_update(input bit r, input bit si, input bit sp, input bit hi);
        bit done;
        if (m_mode == MIdle) begin
            if (m_hp && m_t == 0) m_mode = MHalted;
            else if (r) m_mode = MRun;
            else if (si) begin
                m_mode = MStepInsn;
                m_left = TICKS - m_t;
            end else if (sp) begin
                m_mode = MStepPhase;
                m_left = PW;
            end
        end else if (m_mode != MHalted) begin
            done = (m_t == TICKS - 1);
            m_t = (m_t + 1) % TICKS;
            m_left--;
            if (done) m_count = (m_count + 1) % (1 << CW);
            if (m_mode == MRun) begin
                if (done) m_mode = m_hp ? MHalted : (r ? MRun : MIdle);
            end else if (m_left == 0) begin
                m_mode = (done && m_hp) ? MHalted : MIdle;
            end
        end
        if (hi) m_hp = 1'b1;
    endtask

    task automatic check_outputs(input string tag);
        bit          act;
        logic [31:0] exp_pulse;
        act = (m_mode == MRun) || (m_mode == MStepInsn) || (m_mode == MStepPhase);
        exp_pulse = (act && (m_t % PW == 0)) ? (32'd1 << (m_t / PW)) : 32'd0;
        check({tag, ".pulse"}, 32'(phase_pulse), exp_pulse);
        check({tag, ".done"}, 32'(insn_done), 32'(act && m_t == TICKS - 1));
        check({tag, ".idx"}, 32'(phase_idx), 32'(m_t / PW));
        check({tag, ".count"}, 32'(insn_count), 32'(m_count));
        check({tag, ".state"}, 32'(state_out), 32'(m_mode));
        check({tag, ".running"}, 32'(running), 32'(act));
        check({tag, ".halted"}, 32'(halted), 32'(m_mode == MHalted));
        seen_pulses += $countones(phase_pulse);
        seen_done += int'(insn_done);
    endtask

    // Called at a falling edge; drives inputs for the next rising edge.
    task automatic step_cycle(input bit r, input bit si, input bit sp, input bit hi, input string tag);
        run = r;
        step_insn = si;
        step_phase = sp;
        halt_in = hi;
        @(posedge clock);
        model_update(r, si, sp, hi);
        @(negedge clock);
        check_outputs(tag);
    endtask

    // Asserts reset mid-cycle and checks outputs before any clock edge arrives.
    task automatic apply_reset(input string tag);
        #2;
        reset_n = 1'b0;
        run = 1'b0;
        step_insn = 1'b0;
        step_phase = 1'b0;
        halt_in = 1'b0;
        #1;
        model_reset();
        check_outputs({tag, ".async"});
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        check_outputs({tag, ".release"});
    endtask

    initial begin
        bit rlev;
        reset_n = 1'b0;
        run = 1'b0;
        step_insn = 1'b0;
        step_phase = 1'b0;
        halt_in = 1'b0;
        seen_pulses = 0;
        seen_done = 0;
        model_reset();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        check_outputs("reset");

        // Free run for 25 cycles, then drop run and let the instruction finish.
        seen_pulses = 0;
        seen_done = 0;
        repeat (25) step_cycle(1, 0, 0, 0, "run25");
        check("run25_count", 32'(insn_count), 32'd2);
        check("run25_done", 32'(seen_done), 32'd2);
        repeat (12) step_cycle(0, 0, 0, 0, "run_stop");
        check("run_stop_state", 32'(state_out), 32'(MIdle));
        check("run_stop_count", 32'(insn_count), 32'd3);

        // Single instruction step.
        seen_pulses = 0;
        seen_done = 0;
        step_cycle(0, 1, 0, 0, "sinsn");
        repeat (12) step_cycle(0, 0, 0, 0, "sinsn");
        check("sinsn_pulses", 32'(seen_pulses), 32'd5);
        check("sinsn_done", 32'(seen_done), 32'd1);
        check("sinsn_count", 32'(insn_count), 32'd4);
        check("sinsn_idx", 32'(phase_idx), 32'd0);

        // Five phase steps with idle gaps.
        seen_pulses = 0;
        seen_done = 0;
        for (int k = 0; k < NP; k++) begin
            step_cycle(0, 0, 1, 0, "sphase");
            repeat (3) step_cycle(0, 0, 0, 0, "sphase");
            check("sphase_idx", 32'(phase_idx), 32'((k + 1) % NP));
            check("sphase_done", 32'(seen_done), 32'(k == NP - 1));
        end
        check("sphase_pulses", 32'(seen_pulses), 32'd5);

        // Drop run in phase 1; a step_insn during RUN adds nothing.
        seen_pulses = 0;
        seen_done = 0;
        repeat (3) step_cycle(1, 0, 0, 0, "rundrop");
        step_cycle(0, 1, 0, 0, "rundrop");
        repeat (11) step_cycle(0, 0, 0, 0, "rundrop");
        check("rundrop_pulses", 32'(seen_pulses), 32'd5);
        check("rundrop_done", 32'(seen_done), 32'd1);
        check("rundrop_state", 32'(state_out), 32'(MIdle));

        // Halt raised during phase 2 takes effect at the instruction boundary.
        seen_pulses = 0;
        seen_done = 0;
        repeat (5) step_cycle(1, 0, 0, 0, "halt");
        step_cycle(1, 0, 0, 1, "halt");
        repeat (10) step_cycle(1, 0, 0, 0, "halt");
        step_cycle(1, 1, 0, 0, "halt");
        step_cycle(0, 0, 1, 0, "halt");
        repeat (4) step_cycle(1, 0, 0, 0, "halt");
        check("halt_pulses", 32'(seen_pulses), 32'd5);
        check("halt_halted", 32'(halted), 32'd1);

        // Leave HALTED, run into phase 3, reset asynchronously, restart fresh.
        apply_reset("rst_halt");
        check("rst_halt_count", 32'(insn_count), 32'd0);
        repeat (7) step_cycle(1, 0, 0, 0, "rst_mid");
        check("rst_mid_idx", 32'(phase_idx), 32'd3);
        apply_reset("rst_mid");
        check("rst_mid_state", 32'(state_out), 32'(MIdle));
        step_cycle(1, 0, 0, 0, "fresh");
        check("fresh_p0", 32'(phase_pulse), 32'd1);
        repeat (10) step_cycle(0, 0, 0, 0, "fresh");

        // Random traffic; reset occasionally to leave HALTED.
        rlev = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if (m_mode == MHalted && $urandom_range(0, 15) == 0) begin
                apply_reset("rnd_rst");
            end else begin
                if ($urandom_range(0, 9) == 0) rlev = ~rlev;
                step_cycle(rlev, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                           $urandom_range(0, 149) == 0, "rnd");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
